// File: rtl/cdb_arbiter_pkg.sv
// Shared packet types for the CDB front end.
package cdb_arbiter_pkg;

  localparam int REG_IDX_W   = 5;
  localparam int P_REG_IDX_W = 6;
  localparam int XLEN        = 32;

  // Result as handed over by a functional unit.
  typedef struct packed {
    logic [REG_IDX_W-1:0]   reg_idx;
    logic [P_REG_IDX_W-1:0] p_reg_idx;
    logic [XLEN-1:0]        reg_val;
  } FU_PACKET;

  // Result as broadcast on one CDB lane.
  typedef struct packed {
    logic [REG_IDX_W-1:0]   reg_idx;
    logic [P_REG_IDX_W-1:0] p_reg_idx;
    logic [XLEN-1:0]        reg_val;
    logic                   valid;
  } CDB_PACKET;

  // Wrap a buffered FU result into a live CDB lane value.
  function automatic CDB_PACKET to_cdb(input FU_PACKET p);
    CDB_PACKET c;
    c.reg_idx   = p.reg_idx;
    c.p_reg_idx = p.p_reg_idx;
    c.reg_val   = p.reg_val;
    c.valid     = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_multi_sel.sv
// Rotating-priority selector granting up to REQS requesters per cycle.
// gnt_bus[k] is one-hot (or zero) and marks the k-th grant in rotated order.
module rr_multi_sel #(
  parameter int WIDTH = 4,
  parameter int REQS  = 2,
  localparam int PW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]            req,
  input  logic [PW-1:0]               ptr,
  output logic [WIDTH-1:0]            gnt,
  output logic [REQS-1:0][WIDTH-1:0]  gnt_bus,
  output logic [PW-1:0]               next_ptr
);

  logic [WIDTH-1:0]           req_rot;
  logic [REQS-1:0][WIDTH-1:0] sel_rot;
  logic [WIDTH-1:0]           all_rot;

  // (base + off) mod WIDTH; off never exceeds WIDTH so one subtraction suffices.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= WIDTH) sum = sum - WIDTH;
    return PW'(sum);
  endfunction

  // Rotate requests so the current priority holder sits at bit 0.
  always_comb begin
    req_rot = '0;
    for (int i = 0; i < WIDTH; i++) req_rot[i] = req[wrap_add(ptr, i)];
  end

  // Peel off the lowest remaining request REQS times.
  always_comb begin
    logic [WIDTH-1:0] remaining;
    remaining = req_rot;
    sel_rot   = '0;
    all_rot   = '0;
    for (int k = 0; k < REQS; k++) begin
      sel_rot[k] = remaining & (~remaining + WIDTH'(1));
      remaining  = remaining & ~sel_rot[k];
      all_rot    = all_rot | sel_rot[k];
    end
  end

  // Rotate each grant vector back into FU numbering.
  always_comb begin
    gnt_bus = '0;
    gnt     = '0;
    for (int k = 0; k < REQS; k++) begin
      for (int i = 0; i < WIDTH; i++) gnt_bus[k][wrap_add(ptr, i)] = sel_rot[k][i];
      gnt = gnt | gnt_bus[k];
    end
  end

  // Priority moves to just past the last granted requester; holds if none.
  always_comb begin
    int last_rot;
    last_rot = 0;
    for (int i = 0; i < WIDTH; i++) if (all_rot[i]) last_rot = i;
    next_ptr = (|all_rot) ? wrap_add(ptr, last_rot + 1) : ptr;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB front end: one-entry buffer per FU, up to N round-robin grants per
// cycle onto the broadcast lanes. Buffered results reach the CDB one cycle
// after acceptance at the earliest.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N      = 2,
  parameter int NUM_FU = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      squash,
  input  logic [NUM_FU-1:0]         fu_valid,
  input  FU_PACKET [NUM_FU-1:0]     fu_packet,
  output logic [NUM_FU-1:0]         fu_ready,
  output CDB_PACKET [N-1:0]         entries,
  output logic [NUM_FU-1:0]         cdb_gnt
);

  localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0]         buf_valid;
  FU_PACKET [NUM_FU-1:0]     buf_pkt;
  logic [PW-1:0]             rr_ptr;
  logic [PW-1:0]             next_ptr;
  logic [NUM_FU-1:0]         req;
  logic [NUM_FU-1:0]         gnt;
  logic [NUM_FU-1:0]         accept;
  logic [N-1:0][NUM_FU-1:0]  gnt_bus;
  logic                      blocked;

  // Reset and squash both silence the CDB and refuse new results.
  assign blocked  = reset | squash;
  assign req      = blocked ? '0 : buf_valid;
  assign cdb_gnt  = gnt;
  // A buffer being drained this cycle may take a new result at the same edge.
  assign fu_ready = blocked ? '0 : (~buf_valid | gnt);
  assign accept   = fu_valid & fu_ready;

  rr_multi_sel #(.WIDTH(NUM_FU), .REQS(N)) u_sel (
    .req      (req),
    .ptr      (rr_ptr),
    .gnt      (gnt),
    .gnt_bus  (gnt_bus),
    .next_ptr (next_ptr)
  );

  // Lane k is the OR of all buffers masked by its one-hot grant vector.
  always_comb begin
    entries = '0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < NUM_FU; j++) begin
        entries[k] = entries[k] |
                     ({$bits(CDB_PACKET){gnt_bus[k][j]}} & to_cdb(buf_pkt[j]));
      end
    end
  end

  // Occupancy: load wins over drain, drain clears, otherwise hold.
  always_ff @(posedge clock) begin
    if (reset || squash) buf_valid <= '0;
    else                 buf_valid <= accept | (buf_valid & ~gnt);
  end

  // Payload only changes on acceptance, so a stalled result stays intact.
  always_ff @(posedge clock) begin
    for (int j = 0; j < NUM_FU; j++) begin
      if (accept[j]) buf_pkt[j] <= fu_packet[j];
    end
  end

  // Round-robin pointer advances only when something was broadcast.
  always_ff @(posedge clock) begin
    if (reset)       rr_ptr <= '0;
    else if (|gnt)   rr_ptr <= next_ptr;
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: N=2 and N=1 instances, per-FU scoreboard queues
// filled on acceptance and drained on broadcast, plus directed scenarios.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset, squash;
  logic [3:0]        fv0, fv1, ready0, ready1, gnt0, gnt1;
  FU_PACKET [3:0]    pk0, pk1;
  CDB_PACKET [1:0]   lanes0;
  CDB_PACKET [0:0]   lanes1;
  CDB_PACKET [1:0]   lanes1_pad;

  assign lanes1_pad[0] = lanes1[0];
  assign lanes1_pad[1] = '0;

  cdb_arbiter #(.N(2), .NUM_FU(4)) dut0 (
    .clock(clock), .reset(reset), .squash(squash), .fu_valid(fv0), .fu_packet(pk0),
    .fu_ready(ready0), .entries(lanes0), .cdb_gnt(gnt0));

  cdb_arbiter #(.N(1), .NUM_FU(4)) dut1 (
    .clock(clock), .reset(reset), .squash(squash), .fu_valid(fv1), .fu_packet(pk1),
    .fu_ready(ready1), .entries(lanes1), .cdb_gnt(gnt1));

  int n_chk = 0;
  int n_pass = 0;

  logic [3:0] m_valid [2];
  int         m_rr    [2];
  FU_PACKET   sbq     [2][4][$];
  logic [3:0] acc     [2];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Reference: rotated scan of model occupancy, scoreboard pop on grant, push on accept.
  task automatic model_step(input int u, input int n, input logic [3:0] fv, input FU_PACKET [3:0] pk,
                            input logic [3:0] a_ready, input logic [3:0] a_gnt,
                            input CDB_PACKET [1:0] a_lane, input logic [1:0] a_rr);
    logic [3:0] e_gnt, e_ready;
    int         lane_fu [2];
    int         cnt, j;
    CDB_PACKET  e_lane;
    FU_PACKET   f;
    e_gnt   = '0;
    cnt     = 0;
    lane_fu = '{-1, -1};
    if (!reset) check_eq($sformatf("u%0d_rr", u), {62'd0, a_rr}, 64'(m_rr[u]));
    if (!reset && !squash) begin
      for (int i = 0; i < 4; i++) begin
        j = (m_rr[u] + i) % 4;
        if (m_valid[u][j] && cnt < n) begin
          e_gnt[j] = 1'b1;
          lane_fu[cnt] = j;
          cnt++;
        end
      end
    end
    e_ready = (reset || squash) ? 4'b0000 : (~m_valid[u] | e_gnt);
    check_eq($sformatf("u%0d_gnt", u), {60'd0, a_gnt}, {60'd0, e_gnt});
    check_eq($sformatf("u%0d_ready", u), {60'd0, a_ready}, {60'd0, e_ready});
    for (int k = 0; k < 2; k++) begin
      e_lane = '0;
      if (lane_fu[k] >= 0 && sbq[u][lane_fu[k]].size() > 0) begin
        f = sbq[u][lane_fu[k]].pop_front();
        e_lane.reg_idx   = f.reg_idx;
        e_lane.p_reg_idx = f.p_reg_idx;
        e_lane.reg_val   = f.reg_val;
        e_lane.valid     = 1'b1;
      end
      check_eq($sformatf("u%0d_lane%0d", u, k), 64'(a_lane[k]), 64'(e_lane));
    end
    acc[u] = fv & e_ready;
    if (reset || squash) begin
      m_valid[u] = '0;
      for (int q = 0; q < 4; q++) sbq[u][q].delete();
      if (reset) m_rr[u] = 0;
    end else begin
      for (int q = 0; q < 4; q++) begin
        if (acc[u][q]) begin
          sbq[u][q].push_back(pk[q]);
          m_valid[u][q] = 1'b1;
        end else if (e_gnt[q]) begin
          m_valid[u][q] = 1'b0;
        end
      end
      if (cnt > 0) m_rr[u] = (lane_fu[cnt-1] + 1) % 4;
    end
  endtask

  task automatic tick();
    #1;
    model_step(0, 2, fv0, pk0, ready0, gnt0, lanes0, dut0.rr_ptr);
    model_step(1, 1, fv1, pk1, ready1, gnt1, lanes1_pad, dut1.rr_ptr);
    @(posedge clock);
    #1;
  endtask

  // FUs on dut1 present a fresh result after each acceptance.
  task automatic advance1();
    for (int q = 0; q < 4; q++) begin
      if (acc[1][q]) begin
        pk1[q].reg_val   = pk1[q].reg_val + 32'd1;
        pk1[q].p_reg_idx = pk1[q].p_reg_idx + 6'd1;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    FU_PACKET  saved;
    CDB_PACKET exp_lane;
    int        waits;
    logic      granted;

    m_valid = '{4'b0, 4'b0};
    m_rr    = '{0, 0};
    acc     = '{4'b0, 4'b0};
    reset   = 1'b1;
    squash  = 1'b0;
    fv0     = 4'b1111;
    fv1     = 4'b1111;
    for (int q = 0; q < 4; q++) begin
      pk0[q] = '{reg_idx: 5'(q), p_reg_idx: 6'(q), reg_val: 32'(q + 1)};
      pk1[q] = '{reg_idx: 5'(q), p_reg_idx: 6'(q), reg_val: 32'(q + 1)};
    end

    // Reset held two cycles with every FU requesting.
    for (int c = 0; c < 2; c++) begin
      #1;
      check_eq("rst_ready", {60'd0, ready0}, 64'd0);
      check_eq("rst_lane0", 64'(lanes0[0]), 64'd0);
      check_eq("rst_lane1", 64'(lanes0[1]), 64'd0);
      tick();
    end
    reset = 1'b0;
    fv0   = 4'b0000;
    fv1   = 4'b0000;
    #1;
    check_eq("post_rst_bufv", {60'd0, dut0.buf_valid}, 64'd0);
    check_eq("post_rst_rr", {62'd0, dut0.rr_ptr}, 64'd0);
    tick();

    // N=1: FU0 and FU1 push continuously; grants must alternate.
    pk1[0] = '{reg_idx: 5'd0, p_reg_idx: 6'd0, reg_val: 32'd100};
    pk1[1] = '{reg_idx: 5'd1, p_reg_idx: 6'd0, reg_val: 32'd200};
    fv1 = 4'b0011;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (c > 0) check_eq($sformatf("alt_gnt_c%0d", c), {60'd0, gnt1},
                          (c % 2 == 1) ? 64'h1 : 64'h2);
      tick();
      advance1();
    end
    fv1 = 4'b0000;
    for (int c = 0; c < 3; c++) tick();

    // Four results in one cycle, drained over two cycles of two lanes.
    for (int q = 0; q < 4; q++) pk0[q] = '{reg_idx: 5'(q), p_reg_idx: 6'(q), reg_val: 32'(q + 10)};
    fv0 = 4'b1111;
    tick();
    fv0 = 4'b0000;
    #1;
    check_eq("t1_lane0_val", 64'(lanes0[0].reg_val), 64'd10);
    check_eq("t1_lane1_val", 64'(lanes0[1].reg_val), 64'd11);
    check_eq("t1_lane0_vld", {63'd0, lanes0[0].valid}, 64'd1);
    check_eq("t1_gnt", {60'd0, gnt0}, 64'h3);
    check_eq("t1_ready", {60'd0, ready0}, 64'h3);
    tick();
    #1;
    check_eq("t2_lane0_val", 64'(lanes0[0].reg_val), 64'd12);
    check_eq("t2_lane1_val", 64'(lanes0[1].reg_val), 64'd13);
    check_eq("t2_gnt", {60'd0, gnt0}, 64'hC);
    check_eq("t2_rr", {62'd0, dut0.rr_ptr}, 64'd2);
    tick();
    #1;
    check_eq("t3_rr", {62'd0, dut0.rr_ptr}, 64'd0);
    check_eq("t3_gnt", {60'd0, gnt0}, 64'd0);
    tick();

    // Wrap: steer rr_ptr to 3 via FU1/FU2, then FU3 and FU0 compete.
    pk0[1].reg_val = 32'd21;
    pk0[2].reg_val = 32'd22;
    fv0 = 4'b0110;
    tick();
    pk0[3].reg_val = 32'd33;
    pk0[0].reg_val = 32'd30;
    fv0 = 4'b1001;
    #1;
    check_eq("wrap_pre_gnt", {60'd0, gnt0}, 64'h6);
    check_eq("wrap_pre_ready", {60'd0, ready0}, 64'hF);
    tick();
    fv0 = 4'b0000;
    #1;
    check_eq("wrap_rr3", {62'd0, dut0.rr_ptr}, 64'd3);
    check_eq("wrap_lane0_fu", 64'(lanes0[0].reg_idx), 64'd3);
    check_eq("wrap_lane0_val", 64'(lanes0[0].reg_val), 64'd33);
    check_eq("wrap_lane1_val", 64'(lanes0[1].reg_val), 64'd30);
    check_eq("wrap_gnt", {60'd0, gnt0}, 64'h9);
    tick();
    #1;
    check_eq("wrap_rr1", {62'd0, dut0.rr_ptr}, 64'd1);

    // Squash with all buffers full and FU0 offering a result.
    fv0 = 4'b1111;
    tick();
    squash = 1'b1;
    fv0    = 4'b0001;
    #1;
    check_eq("sq_lane0", 64'(lanes0[0]), 64'd0);
    check_eq("sq_lane1", 64'(lanes0[1]), 64'd0);
    check_eq("sq_ready", {60'd0, ready0}, 64'd0);
    check_eq("sq_gnt", {60'd0, gnt0}, 64'd0);
    tick();
    squash = 1'b0;
    fv0    = 4'b0000;
    #1;
    check_eq("sq_bufv", {60'd0, dut0.buf_valid}, 64'd0);
    check_eq("sq_rr", {62'd0, dut0.rr_ptr}, 64'd1);
    tick();

    // Hold on N=1: park priority at FU3, fill all four, FU2 must wait intact.
    pk1[2].reg_val = 32'hCAFE_0000;
    fv1 = 4'b0100;
    tick();
    advance1();
    fv1 = 4'b0000;
    tick();
    saved = pk1[2];
    fv1 = 4'b1111;
    tick();
    advance1();
    fv1 = 4'b0011;
    granted = 1'b0;
    waits   = 0;
    for (int c = 0; c < 8 && !granted; c++) begin
      #1;
      if (gnt1[2]) begin
        granted = 1'b1;
        exp_lane.reg_idx   = saved.reg_idx;
        exp_lane.p_reg_idx = saved.p_reg_idx;
        exp_lane.reg_val   = saved.reg_val;
        exp_lane.valid     = 1'b1;
        check_eq("hold_lane", 64'(lanes1[0]), 64'(exp_lane));
      end else begin
        waits++;
        check_eq("hold_ready2", {63'd0, ready1[2]}, 64'd0);
        check_eq("hold_pkt", 64'(dut1.buf_pkt[2]), 64'(saved));
      end
      tick();
      advance1();
    end
    check_eq("hold_granted", {63'd0, granted}, 64'd1);
    check_eq("hold_waits", 64'(waits), 64'd3);
    fv1 = 4'b0000;
    for (int c = 0; c < 4; c++) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
